// File: rtl/fpu_addsub_unpack.sv
// fpu_addsub_unpack: unpacks and classifies two IEEE-754 singles for the add/sub datapath; 2-cycle latency,
// valid/ready backpressure at full rate (S1 holds while S2 stalls). Define FPU_DAZ_EN to flush subnormal operands to zero.
module fpu_addsub_unpack #(
    parameter logic [2:0] RM_RESET = 3'b000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        sub_op_i,
    input  logic [2:0]  rm_i,
    input  logic [2:0]  frm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        sign_A_o,
    output logic        sign_B_o,
    output logic [7:0]  exp_A_o,
    output logic [7:0]  exp_B_o,
    output logic [23:0] sig_A_o,
    output logic [23:0] sig_B_o,
    output logic        isZeroA_o,
    output logic        isZeroB_o,
    output logic        isInfA_o,
    output logic        isInfB_o,
    output logic        isNaNA_o,
    output logic        isNaNB_o,
    output logic        isSignaling_o,
    output logic        sub_op_o,
    output logic [2:0]  rm_o,
    output logic        illegal_rm_o
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
        logic        is_snan;
    } opnd_t;

    function automatic opnd_t unpack_op(input logic [31:0] x);
        opnd_t o;
        logic  exp_nz;
        logic  frac_nz;
        exp_nz    = |x[30:23];
        frac_nz   = |x[22:0];
        o.sign    = x[31];
        o.exp     = x[30:23];
        o.sig     = {exp_nz, x[22:0]};
        o.is_zero = !exp_nz && !frac_nz;
`ifdef FPU_DAZ_EN
        if (!exp_nz) begin
            o.sig     = '0;
            o.is_zero = 1'b1;
        end
`endif
        o.is_inf  = (&x[30:23]) && !frac_nz;
        o.is_nan  = (&x[30:23]) && frac_nz;
        // quiet bit clear marks a signaling NaN
        o.is_snan = o.is_nan && !x[22];
        return o;
    endfunction

    logic        r_s1_valid;
    logic [31:0] r_s1_rs1;
    logic [31:0] r_s1_rs2;
    logic        r_s1_sub;
    logic [2:0]  r_s1_rm;

    logic        r_s2_valid;
    opnd_t       r_s2_a;
    opnd_t       r_s2_b;
    logic        r_s2_sub;
    logic [2:0]  r_s2_rm;
    logic        r_s2_illegal;

    logic        w_s2_ready;
    logic        w_in_ready;
    logic        w_accept;
    logic [2:0]  w_rm_res;

    assign w_s2_ready = !r_s2_valid || out_ready_i;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign w_accept   = in_valid_i && w_in_ready && !flush_i;
    assign w_rm_res   = (rm_i == 3'b111) ? frm_i : rm_i;
    assign in_ready_o = w_in_ready;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_ready) r_s1_valid <= w_accept;
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
        end
    end

    // S1 payload is qualified by r_s1_valid, so it needs no reset
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s1_rs1 <= rs1_i;
            r_s1_rs2 <= rs2_i;
            r_s1_sub <= sub_op_i;
            r_s1_rm  <= w_rm_res;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_s2_a       <= '0;
            r_s2_b       <= '0;
            r_s2_sub     <= 1'b0;
            r_s2_rm      <= RM_RESET;
            r_s2_illegal <= 1'b0;
        end else if (r_s1_valid && w_s2_ready) begin
            r_s2_a       <= unpack_op(r_s1_rs1);
            r_s2_b       <= unpack_op(r_s1_rs2);
            r_s2_sub     <= r_s1_sub;
            r_s2_rm      <= r_s1_rm;
            r_s2_illegal <= (r_s1_rm > 3'd4);
        end
    end

    assign out_valid_o   = r_s2_valid;
    assign sign_A_o      = r_s2_valid & r_s2_a.sign;
    assign sign_B_o      = r_s2_valid & r_s2_b.sign;
    assign exp_A_o       = r_s2_valid ? r_s2_a.exp : 8'd0;
    assign exp_B_o       = r_s2_valid ? r_s2_b.exp : 8'd0;
    assign sig_A_o       = r_s2_valid ? r_s2_a.sig : 24'd0;
    assign sig_B_o       = r_s2_valid ? r_s2_b.sig : 24'd0;
    assign isZeroA_o     = r_s2_valid & r_s2_a.is_zero;
    assign isZeroB_o     = r_s2_valid & r_s2_b.is_zero;
    assign isInfA_o      = r_s2_valid & r_s2_a.is_inf;
    assign isInfB_o      = r_s2_valid & r_s2_b.is_inf;
    assign isNaNA_o      = r_s2_valid & r_s2_a.is_nan;
    assign isNaNB_o      = r_s2_valid & r_s2_b.is_nan;
    assign isSignaling_o = r_s2_valid & (r_s2_a.is_snan | r_s2_b.is_snan);
    assign sub_op_o      = r_s2_valid & r_s2_sub;
    assign rm_o          = r_s2_valid ? r_s2_rm : RM_RESET;
    assign illegal_rm_o  = r_s2_valid & r_s2_illegal;

endmodule

// File: doc/fpu_addsub_unpack.md
FPU_ADDSUB_UNPACK -- requirements
Module: fpu_addsub_unpack

Interface
REQ-001 SHALL have parameter RM_RESET, default 3'b000, meaning the rounding mode driven on rm_o while out_valid_o is low and after reset.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush_i, input, 1, synchronous pipeline kill.
REQ-005 SHALL have port in_valid_i / in_ready_o, input / output, 1 each, upstream handshake.
REQ-006 SHALL have port rs1_i / rs2_i, input, 32 each, raw IEEE-754 single operands A / B.
REQ-007 SHALL have port sub_op_i, input, 1, 1 = subtract.
REQ-008 SHALL have port rm_i / frm_i, input, 3 each, instruction rounding field / fcsr.frm.
REQ-009 SHALL have port out_valid_o / out_ready_i, output / input, 1 each, downstream handshake.
REQ-010 SHALL have port sign_A_o, sign_B_o, output, 1 each, operand signs.
REQ-011 SHALL have port exp_A_o, exp_B_o, output, 8 each, raw biased exponents.
REQ-012 SHALL have port sig_A_o, sig_B_o, output, 24 each, {hidden bit, fraction}.
REQ-013 SHALL have port isZeroA_o, isZeroB_o, isInfA_o, isInfB_o, isNaNA_o, isNaNB_o, isSignaling_o, output, 1 each, classification.
REQ-014 SHALL have port sub_op_o, rm_o, output, 1 and 3, forwarded op and resolved rounding mode.
REQ-015 SHALL have port illegal_rm_o, output, 1, resolved rounding mode is not one of 000..100.

Function
REQ-016 SHALL be a two-stage pipeline: S1 captures raw operands, op and resolved rm; S2 holds classified fields; outputs come from S2 registers only.
REQ-017 SHALL accept an input when in_valid_i && in_ready_o && !flush_i; latency from acceptance to out_valid_o is exactly 2 cycles with no stall.
REQ-018 SHALL compute s2_ready = !s2_valid || out_ready_i and in_ready_o = !s1_valid || s2_ready; sustained throughput is 1 op/cycle.
REQ-019 SHALL hold all S2 outputs stable while out_valid_o && !out_ready_i; S1 holds when S2 cannot accept.
REQ-020 SHALL resolve rm as frm_i when rm_i == 3'b111, else rm_i, sampling frm_i in the accept cycle.
REQ-021 SHALL assert illegal_rm_o with out_valid_o when resolved rm is 101, 110 or 111; fields still produced.
REQ-022 SHALL set sig_X_o = {exp != 0, frac}; isZero = exp==0 && frac==0; isInf = exp==255 && frac==0; isNaN = exp==255 && frac!=0.
REQ-023 SHALL set isSignaling_o = (isNaNA && !frac_A[22]) || (isNaNB && !frac_B[22]).
REQ-024 SHALL, on flush_i, clear both valid bits at the next edge regardless of out_ready_i and accept nothing that cycle; data registers need not clear.
REQ-025 SHALL drive rm_o = RM_RESET and every other data output 0 while out_valid_o is low.

Reset
REQ-026 SHALL, on reset_i low, asynchronously clear s1_valid, s2_valid and all S2 data registers, giving out_valid_o = 0, rm_o = RM_RESET, other outputs 0.
REQ-027 SHALL drive in_ready_o = 1 during and after reset until the first acceptance.
REQ-028 SHALL discard any in-flight operation when reset asserts mid-stream; nothing is emitted after release.

Configuration
REQ-029 SHALL, with macro FPU_DAZ_EN defined, treat subnormal operands (exp==0, frac!=0) as zero: sig = 0, isZero = 1, sign kept, exp = 0.
REQ-030 SHALL, without FPU_DAZ_EN, pass subnormals unchanged: sig = {0, frac}, isZero = 0.

Verification
REQ-031 SHALL cover: rs1=0x3F800000, rs2=0x40000000, rm_i=000, out_ready_i=1 -> out_valid_o 2 cycles later, sig_A_o=0x800000, exp_A_o=0x7F, exp_B_o=0x80, all flags 0.
REQ-032 SHALL cover: rs1=0x7F800001, rs2=0xFFC00000 -> isNaNA_o=isNaNB_o=1, isSignaling_o=1; with rs1=0x7FC00000 instead -> isSignaling_o=0.
REQ-033 SHALL cover: rs1=0x00000001 -> without FPU_DAZ_EN sig_A_o=0x000001, isZeroA_o=0; with FPU_DAZ_EN sig_A_o=0, isZeroA_o=1.
REQ-034 SHALL cover: 4 back-to-back ops with out_ready_i=0 for 3 cycles -> in_ready_o falls after 2 accepts, outputs held constant, all 4 emitted in order once released.
REQ-035 SHALL cover: rm_i=111, frm_i=010 -> rm_o=010, illegal_rm_o=0; rm_i=111, frm_i=101 -> illegal_rm_o=1.
REQ-036 SHALL cover: flush_i or reset_i low with both stages full -> next cycle out_valid_o=0, in_ready_o=1, no stale output emitted.
